// File: rtl/usb_rx_packet_buffer.sv
// Receive-side packet FIFO for a USB full-speed receiver: bytes are written speculatively
// and become visible to the backend only once the packet's last byte arrives with keepPacket set.
module usb_rx_packet_buffer #(
    parameter int unsigned DEPTH_LOG2 = 6
) (
    input  logic                  clk48,
    input  logic                  RST,
    output logic                  rxAcceptNewData,
    input  logic                  rxDataValid,
    input  logic [7:0]            rxData,
    input  logic                  rxIsLastByte,
    input  logic                  keepPacket,
    input  logic                  rdEn,
    output logic                  rdValid,
    output logic [7:0]            rdData,
    output logic                  rdIsLast,
    output logic [DEPTH_LOG2:0]   pktCount,
    output logic [7:0]            dropCount,
    output logic                  overflow
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned PW    = DEPTH_LOG2 + 1;

    typedef enum logic {
        WR_RECV,
        WR_DISCARD
    } wr_state_t;

    wr_state_t         state;
    logic [8:0]        mem [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     commit_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     used;
    logic [8:0]        head;
    logic              xfer;
    logic              full;
    logic              do_write;
    logic              commit;
    logic              drop;
    logic              pop;
    logic              pop_last;

    always_comb begin
        used     = wr_ptr - rd_ptr;
        full     = (used == PW'(DEPTH));
        xfer     = rxDataValid && rxAcceptNewData;
        do_write = xfer && (state == WR_RECV) && !full;
        commit   = do_write && rxIsLastByte && keepPacket;
        // every last byte that does not commit ends a discarded packet
        drop     = xfer && rxIsLastByte && !commit;
        head     = mem[rd_ptr[DEPTH_LOG2-1:0]];
        rdValid  = (rd_ptr != commit_ptr);
        rdData   = head[7:0];
        rdIsLast = head[8];
        pop      = rdEn && rdValid;
        pop_last = pop && head[8];
    end

    // Storage array; contents are meaningless until covered by commit_ptr, so no reset
    always_ff @(posedge clk48) begin
        if (do_write) begin
            mem[wr_ptr[DEPTH_LOG2-1:0]] <= {rxIsLastByte, rxData};
        end
    end

    // Write FSM, pointers and status counters
    always_ff @(posedge clk48) begin
        if (RST) begin
            state           <= WR_RECV;
            wr_ptr          <= '0;
            commit_ptr      <= '0;
            rd_ptr          <= '0;
            pktCount        <= '0;
            dropCount       <= '0;
            overflow        <= 1'b0;
            rxAcceptNewData <= 1'b0;
        end else begin
            rxAcceptNewData <= 1'b1;

            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end

            if (drop) begin
                wr_ptr <= commit_ptr;
                if (dropCount != 8'hFF) begin
                    dropCount <= dropCount + 8'd1;
                end
            end else if (do_write) begin
                wr_ptr <= wr_ptr + PW'(1);
                if (commit) begin
                    commit_ptr <= wr_ptr + PW'(1);
                end
            end

            if (xfer) begin
                case (state)
                    WR_RECV: begin
                        if (full) begin
                            overflow <= 1'b1;
                            if (!rxIsLastByte) begin
                                state <= WR_DISCARD;
                            end
                        end
                    end
                    WR_DISCARD: begin
                        if (rxIsLastByte) begin
                            state <= WR_RECV;
                        end
                    end
                    default: state <= WR_RECV;
                endcase
            end

            case ({commit, pop_last})
                2'b10:   pktCount <= pktCount + PW'(1);
                2'b01:   pktCount <= pktCount - PW'(1);
                default: pktCount <= pktCount;
            endcase
        end
    end

endmodule
